// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, absorbs the one-cycle ROM read latency
// through a skid buffer, and handles branch redirects, halt and retire counting.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  input  logic [23:0] rom_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [23:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] retired_count
);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] f_pc_q, f_pc_d;
  logic        f_v_q, f_v_d;
  logic [23:0] hold_instr_q, hold_instr_d;
  logic [15:0] hold_pc_q, hold_pc_d;
  logic        hold_v_q, hold_v_d;
  logic [15:0] cnt_q, cnt_d;

  logic accept;
  logic halt_accept;

  always_comb begin
    instr_out   = hold_v_q ? hold_instr_q : rom_data;
    instr_pc    = hold_v_q ? hold_pc_q : f_pc_q;
    instr_valid = (hold_v_q | f_v_q) & (state_q == RUN) & ~redirect_valid;
    accept      = instr_valid & ~stall;
    halt_accept = accept & (instr_out[23:20] == HALT_OPCODE);
  end

  assign rom_addr      = pc_q;
  assign halted        = (state_q == HALT);
  assign retired_count = cnt_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    f_pc_d       = f_pc_q;
    f_v_d        = f_v_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_v_d     = hold_v_q;
    cnt_d        = cnt_q;

    if (state_q == RUN) begin
      if (redirect_valid) begin
        pc_d     = redirect_target;
        f_v_d    = 1'b0;
        hold_v_d = 1'b0;
      end else if (halt_accept) begin
        state_d  = HALT;
        f_v_d    = 1'b0;
        hold_v_d = 1'b0;
      end else if (stall) begin
        // Capture the live ROM word; the read issued this cycle is dropped and
        // re-issued later because pc is left pointing at it.
        if (!hold_v_q) begin
          if (f_v_q) begin
            hold_instr_d = rom_data;
            hold_pc_d    = f_pc_q;
            hold_v_d     = 1'b1;
          end
          f_v_d = 1'b0;
        end
      end else begin
        f_pc_d   = pc_q;
        f_v_d    = 1'b1;
        pc_d     = pc_q + 16'd1;
        hold_v_d = 1'b0;
      end

      if (accept && (cnt_q != '1)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      f_pc_q       <= '0;
      f_v_q        <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_v_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      f_pc_q       <= f_pc_d;
      f_v_q        <= f_v_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_v_q     <= hold_v_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (RESET_PC 0 and FFFE) against a
// presented-instruction model, plus directed literal expectations.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;

  logic [15:0] addr1, ipc1, cnt1, addr2, ipc2, cnt2;
  logic [23:0] rd1, ins1, rd2, ins2;
  logic        v1, h1, v2, h2;

  logic [23:0] mem [0:65535];

  int unsigned n_pass;
  int unsigned n_total;

  fetch_unit #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .rom_addr(addr1), .rom_data(rd1), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_out(ins1), .instr_pc(ipc1), .instr_valid(v1), .halted(h1),
    .retired_count(cnt1)
  );

  fetch_unit #(.RESET_PC(16'hFFFE), .HALT_OPCODE(4'hF)) dut2 (
    .clk(clk), .rst(rst), .rom_addr(addr2), .rom_data(rd2), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_out(ins2), .instr_pc(ipc2), .instr_valid(v2), .halted(h2),
    .retired_count(cnt2)
  );

  always @(posedge clk) rd1 <= mem[addr1];
  always @(posedge clk) rd2 <= mem[addr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what decode sees. cur = address of the presented word (cur_v says
  // one is presented), nxt = next address the fetch unit will request.
  typedef struct packed {
    logic [15:0] nxt;
    logic [15:0] cur;
    logic        cur_v;
    logic        halt;
    logic [15:0] cnt;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mreset(input logic [15:0] start);
    mdl_t r;
    r.nxt   = start;
    r.cur   = 16'h0000;
    r.cur_v = 1'b0;
    r.halt  = 1'b0;
    r.cnt   = 16'h0000;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input logic st, input logic rv,
                                 input logic [15:0] tg);
    mdl_t r;
    logic acc;
    r = s;
    if (s.halt) return r;
    acc = s.cur_v && !rv && !st;
    if (acc && s.cnt != 16'hFFFF) r.cnt = s.cnt + 16'd1;
    if (rv) begin
      r.cur_v = 1'b0;
      r.nxt   = tg;
    end else if (acc && mem[s.cur][23:20] == 4'hF) begin
      r.halt = 1'b1;
    end else if (!st) begin
      r.cur   = s.nxt;
      r.cur_v = 1'b1;
      r.nxt   = s.nxt + 16'd1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= mreset(16'h0000);
      m2 <= mreset(16'hFFFE);
    end else begin
      m1 <= mstep(m1, stall, redirect_valid, redirect_target);
      m2 <= mstep(m2, stall, redirect_valid, redirect_target);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cmp(input string nm, input mdl_t m, input logic v, input logic h,
                     input logic [15:0] cnt, input logic [15:0] addr,
                     input logic [15:0] pc, input logic [23:0] ins);
    logic ev;
    ev = m.cur_v && !m.halt && !redirect_valid;
    check({nm, ".valid"}, {31'd0, v}, {31'd0, ev});
    check({nm, ".halted"}, {31'd0, h}, {31'd0, m.halt});
    check({nm, ".count"}, {16'd0, cnt}, {16'd0, m.cnt});
    if (!m.halt) check({nm, ".rom_addr"}, {16'd0, addr}, {16'd0, m.nxt});
    if (ev) begin
      check({nm, ".instr_pc"}, {16'd0, pc}, {16'd0, m.cur});
      check({nm, ".instr_out"}, {8'd0, ins}, {8'd0, mem[m.cur]});
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      cmp("dut", m1, v1, h1, cnt1, addr1, ipc1, ins1);
      cmp("dut2", m2, v2, h2, cnt2, addr2, ipc2, ins2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = {8'h30, i[15:0]};
    end
    mem[0] = 24'h000000;
    mem[1] = 24'h000010;
    mem[2] = 24'h120000;

    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 16'h0000;
    #12;
    check("rst_addr", {16'd0, addr1}, 32'h0000);
    check("rst_addr2", {16'd0, addr2}, 32'hFFFE);
    check("rst_valid", {31'd0, v1}, 32'd0);
    check("rst_halted", {31'd0, h1}, 32'd0);
    check("rst_count", {16'd0, cnt1}, 32'd0);
    rst = 1'b0;
    #1;
    check("c0_valid", {31'd0, v1}, 32'd0);

    // Reset release and in-order stream
    tick(); #1;
    check("c1_valid", {31'd0, v1}, 32'd1);
    check("c1_instr", {8'd0, ins1}, 32'h000000);
    check("c1_pc", {16'd0, ipc1}, 32'h0000);
    check("c1_addr", {16'd0, addr1}, 32'h0001);
    check("c1_pc2", {16'd0, ipc2}, 32'hFFFE);
    tick(); #1;
    check("c2_instr", {8'd0, ins1}, 32'h000010);
    check("c2_pc", {16'd0, ipc1}, 32'h0001);
    check("c2_count", {16'd0, cnt1}, 32'd1);
    check("c2_addr", {16'd0, addr1}, 32'h0002);
    check("c2_pc2", {16'd0, ipc2}, 32'hFFFF);

    // Three stall cycles while pc 2 is presented
    tick(); stall = 1'b1; #1;
    check("c3_instr", {8'd0, ins1}, 32'h120000);
    check("c3_pc", {16'd0, ipc1}, 32'h0002);
    check("c3_count", {16'd0, cnt1}, 32'd2);
    check("c3_pc2", {16'd0, ipc2}, 32'h0000);
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      check("stall_instr", {8'd0, ins1}, 32'h120000);
      check("stall_pc", {16'd0, ipc1}, 32'h0002);
      check("stall_valid", {31'd0, v1}, 32'd1);
    end
    tick(); stall = 1'b0; #1;
    check("rel_pc", {16'd0, ipc1}, 32'h0002);
    tick(); #1;
    check("after_rel_instr", {8'd0, ins1}, 32'h300003);
    check("after_rel_pc", {16'd0, ipc1}, 32'h0003);
    check("after_rel_count", {16'd0, cnt1}, 32'd3);
    check("after_rel_pc2", {16'd0, ipc2}, 32'h0001);

    // Redirect to 7 while pc 10 is presented
    n = 0;
    while (!(v1 === 1'b1 && ipc1 === 16'd10) && n < 20) begin
      tick(); #1;
      n++;
    end
    check("reach_pc10", n, 32'd7);
    redirect_valid = 1'b1; redirect_target = 16'h0007; #1;
    check("redir_squash", {31'd0, v1}, 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    check("redir_bubble", {31'd0, v1}, 32'd0);
    tick(); #1;
    check("redir_valid", {31'd0, v1}, 32'd1);
    check("redir_pc", {16'd0, ipc1}, 32'h0007);
    check("redir_count", {16'd0, cnt1}, 32'd10);
    tick(); #1;
    check("redir_pc8", {16'd0, ipc1}, 32'h0008);

    // Redirect with stall while the skid buffer is occupied
    stall = 1'b1; #1;
    tick(); #1;
    check("hold_pc8", {16'd0, ipc1}, 32'h0008);
    redirect_valid = 1'b1; redirect_target = 16'h0020; #1;
    check("rs_squash", {31'd0, v1}, 32'd0);
    tick(); redirect_valid = 1'b0; stall = 1'b0; #1;
    check("rs_bubble", {31'd0, v1}, 32'd0);
    tick(); #1;
    check("rs_valid", {31'd0, v1}, 32'd1);
    check("rs_pc", {16'd0, ipc1}, 32'h0020);
    check("rs_instr", {8'd0, ins1}, 32'h300020);
    check("rs_count", {16'd0, cnt1}, 32'd11);

    // Halt opcode at address 4
    rst = 1'b1; mem[4] = 24'hF00000; #1;
    check("rst2_count", {16'd0, cnt1}, 32'd0);
    tick(); rst = 1'b0; #1;
    n = 0;
    while (!(v1 === 1'b1 && ipc1 === 16'd4) && n < 20) begin
      tick(); #1;
      n++;
    end
    check("reach_pc4", n, 32'd5);
    check("halt_instr", {8'd0, ins1}, 32'hF00000);
    check("pre_halted", {31'd0, h1}, 32'd0);
    tick(); #1;
    check("halted", {31'd0, h1}, 32'd1);
    check("halt_valid", {31'd0, v1}, 32'd0);
    check("halt_count", {16'd0, cnt1}, 32'd5);
    redirect_valid = 1'b1; redirect_target = 16'h0000; #1;
    tick(); redirect_valid = 1'b0;
    repeat (4) tick();
    #1;
    check("halt_stays", {31'd0, h1}, 32'd1);
    check("halt_stays_valid", {31'd0, v1}, 32'd0);
    check("halt_stays_count", {16'd0, cnt1}, 32'd5);
    rst = 1'b1; #1;
    check("rst_clears_halt", {31'd0, h1}, 32'd0);
    tick(); rst = 1'b0; #1;
    tick(); #1;
    check("restart_pc", {16'd0, ipc1}, 32'h0000);
    check("restart_valid", {31'd0, v1}, 32'd1);

    // Asynchronous reset in the middle of a stall
    tick(); tick(); stall = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, v1}, 32'd0);
    check("arst_halted", {31'd0, h1}, 32'd0);
    check("arst_count", {16'd0, cnt1}, 32'd0);
    check("arst_addr", {16'd0, addr1}, 32'h0000);
    check("arst_addr2", {16'd0, addr2}, 32'hFFFE);
    check("arst_valid2", {31'd0, v2}, 32'd0);
    #10 rst = 1'b0; stall = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 24-bit instruction ROM.
- Owns the program counter and drives the ROM address.
- Absorbs the ROM's one-cycle registered read latency and presents the instruction, with its PC, to decode through a valid/stall handshake.
- Handles branch redirects from execute, a halt opcode, and a saturating count of retired instructions.

Parameters:
- RESET_PC, 16'h0000, first address fetched after reset.
- HALT_OPCODE, 4'hF, opcode (instr[23:20]) that stops fetching once accepted.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  16  address to ROM; equals the internal pc register.
- rom_data  in  24  ROM output; holds mem[addr sampled at the previous edge].
- stall  in  1  decode cannot accept this cycle.
- redirect_valid  in  1  execute requests a PC change (branch).
- redirect_target  in  16  new PC when redirect_valid=1.
- instr_out  out  24  instruction presented to decode.
- instr_pc  out  16  address of instr_out; used by ldpc.
- instr_valid  out  1  instr_out is meaningful.
- halted  out  1  a HALT_OPCODE instruction has been accepted.
- retired_count  out  16  accepted-instruction count; saturates at 16'hFFFF.

Behaviour:
- Registers:
  - pc: next address to issue.
  - f_pc / f_v: in-flight ROM read.
  - hold_instr / hold_pc / hold_v: skid buffer.
  - state: RUN or HALT.
  - retired_count.
- Reset (async, rst=1): pc=RESET_PC, f_v=0, hold_v=0, state=RUN, retired_count=0. Therefore instr_valid=0, halted=0, rom_addr=RESET_PC.
- Output mux (combinational):
  - If hold_v: instr_out=hold_instr, instr_pc=hold_pc.
  - Otherwise: instr_out=rom_data, instr_pc=f_pc.
  - instr_valid = (hold_v | f_v) & (state==RUN) & ~redirect_valid.
- accept = instr_valid & ~stall.
- Issue: in RUN with no redirect, issue when (hold_v=0 and stall=0) or (hold_v=1 and stall=0). Issue means the ROM samples rom_addr=pc at the edge; then f_pc<=pc, f_v<=1, pc<=pc+1. pc wraps 16'hFFFF -> 16'h0000. Otherwise f_v<=0 and pc holds.
- Latency: an address issued at edge N appears on instr_out in the cycle after edge N. First valid instruction is mem[RESET_PC], one cycle after reset is released.
- Stall capture: if stall=1, f_v=1 and hold_v=0, then hold_instr<=rom_data, hold_pc<=f_pc, hold_v<=1.
  - The ROM read issued in that cycle is discarded (f_v<=0); pc still points to it, so it is re-issued.
- Stall while hold_v=1: all state holds.
- Release: hold_v=1 and stall=0 in RUN with no redirect: hold is consumed (hold_v<=0) and pc is issued in the same cycle, so there is no bubble.
- Redirect (highest priority in RUN):
  - pc<=redirect_target, f_v<=0, hold_v<=0.
  - The instruction presented that cycle is squashed: instr_valid=0 and it is not counted.
  - The target is issued on the following edge and appears valid 2 cycles after the redirect cycle.
  - Redirect together with stall: the redirect still wins.
- Halt: on accept of an instruction with instr[23:20]==HALT_OPCODE:
  - state<=HALT, f_v<=0, hold_v<=0; that instruction is counted.
  - In HALT: halted=1, instr_valid=0, pc frozen, redirect ignored. Only rst exits HALT.
- retired_count increments on every accept, including the halt instruction, and saturates at 16'hFFFF.
- Reset mid-operation: all registers clear immediately regardless of stall, redirect or hold contents.

Test Plan:
1. Reset release, ROM mem[0]=24'h000000, mem[1]=24'h000010, mem[2]=24'h120000, no stall. Required: rom_addr 0,1,2,... on successive cycles; instr_valid rises one cycle after reset release; instr_out/instr_pc sequence is (000000,0), (000010,1), (120000,2); retired_count=3 after three cycles.
2. Assert stall for 3 cycles while instr_pc=2. Required: instr_out stays 24'h120000 and instr_pc stays 2 for all 3 cycles. On release, next cycle shows mem[3] at pc 3 with no bubble and no duplicate.
3. Redirect to 16'h0007 while instr_pc=10 is presented. Required: instr_valid=0 that cycle and the next; then instr_pc=7, 8, ...; pc 10's instruction is not counted.
4. Redirect asserted together with stall=1 while hold_v=1. Required: hold is discarded and the target appears 2 cycles later.
5. ROM word 24'hF00000 at address 4. Required: it is presented and accepted, then halted=1 and instr_valid=0 permanently. Redirect to 0 has no effect; rst clears halted and fetch restarts at RESET_PC.
6. RESET_PC=16'hFFFE. Required: instr_pc sequence FFFE, FFFF, 0000, 0001. Also assert rst mid-stall: all outputs clear asynchronously.
